// File: rtl/regfile_onehot32_if.sv
// rtl/regfile_onehot32_if.sv - write/read bus between datapath and the one-hot register file
//
// Purpose: bundles the register file's write port (one-hot select), both
// read ports and the sticky error flag into one connection.
// Signals:
//   wr_en     write request for the current cycle
//   wr_sel    one-hot write select from the 5-to-32 decoder
//   wr_data   data to write
//   rd_sel_a  read port A register number
//   rd_sel_b  read port B register number
//   rd_data_a contents of register rd_sel_a
//   rd_data_b contents of register rd_sel_b
//   wr_err    sticky multi-hot write flag
// Modports: master = datapath side, slave = register file side.
interface regfile_onehot32_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  wr_en;
    logic [31:0]           wr_sel;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [4:0]            rd_sel_a;
    logic [4:0]            rd_sel_b;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic                  wr_err;

    modport master (
        output wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b,
        input  rd_data_a, rd_data_b, wr_err
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b,
        output rd_data_a, rd_data_b, wr_err
    );
endinterface

// File: rtl/regfile_onehot32.sv
// rtl/regfile_onehot32.sv - 32-entry register file with one-hot write select and two async read ports
//
// Purpose: 32 x DATA_WIDTH register file fed by a one-hot write select.
// Multi-hot writes are suppressed and raise a sticky error. Entry 0 can be
// hardwired to zero (ZERO_REG=1).
// Ports:
//   clock  design clock, state updates on the rising edge
//   reset  asynchronous active-high reset, clears all registers and wr_err
//   bus    regfile_onehot32_if.slave (write port, two read ports, wr_err)
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward a valid
// same-cycle write onto the read ports before the clock edge.
module regfile_onehot32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_onehot32_if.slave    bus
);
    logic [DATA_WIDTH-1:0] regs_q [32];
    logic [DATA_WIDTH-1:0] regs_d [32];
    logic                  err_q;
    logic                  err_d;

    logic                  sel_nonzero;
    logic                  sel_multi_hot;
    logic                  valid_write;

    // x & (x-1) clears the lowest set bit; anything left means two or more bits set.
    assign sel_nonzero   = (bus.wr_sel != 32'd0);
    assign sel_multi_hot = ((bus.wr_sel & (bus.wr_sel - 32'd1)) != 32'd0);
    assign valid_write   = bus.wr_en && sel_nonzero && !sel_multi_hot;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (valid_write && bus.wr_sel[i]) begin
                regs_d[i] = bus.wr_data;
            end
        end
        // Entry 0 storage is pinned to zero so its read path needs no special case.
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
        end
        // wr_sel is only examined for errors when a write is requested.
        err_d = err_q | (bus.wr_en & sel_multi_hot);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            err_q <= err_d;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic bypass_a;
    logic bypass_b;

    // Reset gates the bypass so the ports still read zero while reset is held.
    always_comb begin
        bypass_a = !reset && valid_write && bus.wr_sel[bus.rd_sel_a]
                   && !((ZERO_REG != 0) && (bus.rd_sel_a == 5'd0));
        bypass_b = !reset && valid_write && bus.wr_sel[bus.rd_sel_b]
                   && !((ZERO_REG != 0) && (bus.rd_sel_b == 5'd0));
        bus.rd_data_a = bypass_a ? bus.wr_data : regs_q[bus.rd_sel_a];
        bus.rd_data_b = bypass_b ? bus.wr_data : regs_q[bus.rd_sel_b];
    end
`else
    assign bus.rd_data_a = regs_q[bus.rd_sel_a];
    assign bus.rd_data_b = regs_q[bus.rd_sel_b];
`endif

    assign bus.wr_err = err_q;
endmodule

// File: tb/tb_regfile_onehot32.sv
// tb/tb_regfile_onehot32.sv - directed self-checking bench for regfile_onehot32
module tb_regfile_onehot32;
    logic clock;
    logic reset;
    int   n_vec;
    int   n_bad;

    regfile_onehot32_if #(.DATA_WIDTH(32)) bus ();

    regfile_onehot32 #(.DATA_WIDTH(32), .ZERO_REG(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a write at the falling edge, let one rising edge pass, then drop wr_en.
    task automatic do_write(input logic en, input logic [31:0] sel, input logic [31:0] data);
        @(negedge clock);
        bus.wr_en   = en;
        bus.wr_sel  = sel;
        bus.wr_data = data;
        @(posedge clock);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
        bus.rd_sel_a = a;
        bus.rd_sel_b = b;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_sel   = 32'd0;
        bus.wr_data  = 32'd0;
        bus.rd_sel_a = 5'd0;
        bus.rd_sel_b = 5'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Prior contents, then reset wipes them.
        do_write(1'b1, 32'h0000_0020, 32'hCAFE_0005);
        do_write(1'b1, 32'h8000_0000, 32'hCAFE_001F);
        set_rd(5'd5, 5'd31);
        check("pre_reset_r5", bus.rd_data_a, 32'hCAFE_0005);
        check("pre_reset_r31", bus.rd_data_b, 32'hCAFE_001F);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset_r5", bus.rd_data_a, 32'h0);
        check("reset_r31", bus.rd_data_b, 32'h0);
        check("reset_err", {31'd0, bus.wr_err}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Basic write/read, same-cycle read before the edge.
        @(negedge clock);
        set_rd(5'd3, 5'd3);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 32'h0000_0008;
        bus.wr_data = 32'hDEAD_BEEF;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("same_cycle_r3", bus.rd_data_a, 32'hDEAD_BEEF);
`else
        check("same_cycle_r3", bus.rd_data_a, 32'h0);
`endif
        @(posedge clock);
        #1;
        bus.wr_en = 1'b0;
        check("after_edge_r3_a", bus.rd_data_a, 32'hDEAD_BEEF);
        check("after_edge_r3_b", bus.rd_data_b, 32'hDEAD_BEEF);

        // Zero register: write accepted silently, reads 0 even mid-cycle.
        @(negedge clock);
        set_rd(5'd0, 5'd3);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 32'h0000_0001;
        bus.wr_data = 32'h1234_5678;
        #1;
        check("zero_same_cycle", bus.rd_data_a, 32'h0);
        @(posedge clock);
        #1;
        bus.wr_en = 1'b0;
        check("zero_after", bus.rd_data_a, 32'h0);
        check("zero_err", {31'd0, bus.wr_err}, 32'h0);

        // Disabled write with all-ones select: ignored, no error.
        do_write(1'b0, 32'hFFFF_FFFF, 32'h0000_0BAD);
        set_rd(5'd3, 5'd5);
        check("disabled_r3", bus.rd_data_a, 32'hDEAD_BEEF);
        check("disabled_r5", bus.rd_data_b, 32'h0);
        check("disabled_err", {31'd0, bus.wr_err}, 32'h0);

        // Enabled write with empty select: no write, no error.
        do_write(1'b1, 32'h0, 32'h0000_0BAD);
        check("empty_r3", bus.rd_data_a, 32'hDEAD_BEEF);
        check("empty_err", {31'd0, bus.wr_err}, 32'h0);

        // Multi-hot write suppressed and flagged; no bypass either.
        do_write(1'b1, 32'h0000_0002, 32'h0000_0011);
        do_write(1'b1, 32'h0000_0004, 32'h0000_0022);
        @(negedge clock);
        set_rd(5'd1, 5'd2);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 32'h0000_0006;
        bus.wr_data = 32'h0000_FFFF;
        #1;
        check("multi_no_bypass", bus.rd_data_a, 32'h0000_0011);
        @(posedge clock);
        #1;
        bus.wr_en = 1'b0;
        check("multi_r1", bus.rd_data_a, 32'h0000_0011);
        check("multi_r2", bus.rd_data_b, 32'h0000_0022);
        check("multi_err", {31'd0, bus.wr_err}, 32'h1);
        do_write(1'b1, 32'h0000_0010, 32'h0000_0044);
        set_rd(5'd4, 5'd4);
        check("after_multi_r4", bus.rd_data_a, 32'h0000_0044);
        check("err_sticky", {31'd0, bus.wr_err}, 32'h1);

        // Top entry through both ports.
        do_write(1'b1, 32'h8000_0000, 32'h8765_4321);
        set_rd(5'd31, 5'd31);
        check("r31_a", bus.rd_data_a, 32'h8765_4321);
        check("r31_b", bus.rd_data_b, 32'h8765_4321);

        // Async reset while a write to reg 7 is pending.
        do_write(1'b1, 32'h0000_0080, 32'hA5A5_A5A5);
        set_rd(5'd7, 5'd4);
        check("r7_loaded", bus.rd_data_a, 32'hA5A5_A5A5);
        @(negedge clock);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 32'h0000_0080;
        bus.wr_data = 32'h0000_0077;
        #2;
        reset = 1'b1;
        #1;
        check("async_r7", bus.rd_data_a, 32'h0);
        check("async_err", {31'd0, bus.wr_err}, 32'h0);
        @(posedge clock);
        #1;
        check("edge_under_reset_r7", bus.rd_data_a, 32'h0);
        check("edge_under_reset_r4", bus.rd_data_b, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        bus.wr_en = 1'b0;
        check("first_edge_after_reset_r7", bus.rd_data_a, 32'h0000_0077);
        check("first_edge_after_reset_err", {31'd0, bus.wr_err}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
